// File: rtl/expr_sched.sv
// Two-requester sequencer evaluating res = 3*a - 2*b on a shared shift-add datapath.
// Round-robin grant in IDLE, then DBL/ADD/SUB build the result, held in DONE until accepted.
module expr_sched #(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req0_valid,
   input  logic signed [WIDTH-1:0] req0_a,
   input  logic signed [WIDTH-1:0] req0_b,
   output logic                    req0_ready,
   input  logic                    req1_valid,
   input  logic signed [WIDTH-1:0] req1_a,
   input  logic signed [WIDTH-1:0] req1_b,
   output logic                    req1_ready,
   output logic                    res_valid,
   output logic signed [WIDTH-1:0] res_data,
   output logic                    res_id,
   input  logic                    res_ready,
   output logic                    busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DBL,
      S_ADD,
      S_SUB,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic signed [WIDTH-1:0] a_q, a_d;
   logic signed [WIDTH-1:0] b_q, b_d;
   logic signed [WIDTH-1:0] acc_q, acc_d;
   logic                    res_id_q, res_id_d;
   logic                    last_q, last_d;
   logic                    busy_q, busy_d;
   logic                    grant0, grant1;

   // All datapath arithmetic wraps modulo 2^WIDTH; the result width truncates.
   function automatic logic signed [WIDTH-1:0] wrap_dbl(input logic signed [WIDTH-1:0] x);
      return x <<< 1;
   endfunction

   function automatic logic signed [WIDTH-1:0] wrap_add(input logic signed [WIDTH-1:0] x,
                                                        input logic signed [WIDTH-1:0] y);
      return x + y;
   endfunction

   function automatic logic signed [WIDTH-1:0] wrap_sub(input logic signed [WIDTH-1:0] x,
                                                        input logic signed [WIDTH-1:0] y);
      return x - y;
   endfunction

   always_comb begin
      // On a tie the requester that did not win last time takes the grant.
      grant0     = req0_valid & (~req1_valid | last_q);
      grant1     = req1_valid & (~req0_valid | ~last_q);
      req0_ready = (state_q == S_IDLE) & ~rst & grant0;
      req1_ready = (state_q == S_IDLE) & ~rst & grant1;

      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      res_id_d = res_id_q;
      last_d   = last_q;

      case (state_q)
         S_IDLE: begin
            if (req0_ready) begin
               a_d      = req0_a;
               b_d      = req0_b;
               res_id_d = 1'b0;
               last_d   = 1'b0;
               state_d  = S_DBL;
            end else if (req1_ready) begin
               a_d      = req1_a;
               b_d      = req1_b;
               res_id_d = 1'b1;
               last_d   = 1'b1;
               state_d  = S_DBL;
            end
         end
         S_DBL: begin
            acc_d   = wrap_dbl(a_q);
            state_d = S_ADD;
         end
         S_ADD: begin
            acc_d   = wrap_add(acc_q, a_q);
            state_d = S_SUB;
         end
         S_SUB: begin
            acc_d   = wrap_sub(acc_q, wrap_dbl(b_q));
            state_d = S_DONE;
         end
         S_DONE: begin
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         res_id_q <= 1'b0;
         last_q   <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         res_id_q <= res_id_d;
         last_q   <= last_d;
         busy_q   <= busy_d;
      end
   end

   assign res_valid = (state_q == S_DONE);
   assign res_data  = acc_q;
   assign res_id    = res_id_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_expr_sched.sv
// Directed bench for expr_sched: single ops, wrap-around, fairness, backpressure and mid-op reset.
module tb_expr_sched;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_valid, req1_valid;
   logic signed [7:0] req0_a, req0_b, req1_a, req1_b;
   logic              req0_ready, req1_ready;
   logic              res_valid;
   logic signed [7:0] res_data;
   logic              res_id;
   logic              res_ready;
   logic              busy;

   int tests = 0;
   int fails = 0;

   expr_sched #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_id     (res_id),
      .res_ready  (res_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   // Issue one pair from requester id (from IDLE, res_ready high) and check the tagged result.
   task automatic do_op(input string tag, input bit id, input logic signed [7:0] a,
                        input logic signed [7:0] b, input logic signed [7:0] exp);
      int n;
      if (id == 1'b0) begin
         req0_a = a; req0_b = b; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_valid = 1'b1;
      end
      #1;
      check({tag, "_ready"}, {31'd0, (id ? req1_ready : req0_ready)}, 32'd1);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      n = 1;
      while (!res_valid && n < 10) begin
         step();
         n++;
      end
      check({tag, "_latency"}, n, 32'd4);
      check({tag, "_data"}, {24'd0, res_data}, {24'd0, exp});
      check({tag, "_id"}, {31'd0, res_id}, {31'd0, id});
      step();
      check({tag, "_vld_drop"}, {31'd0, res_valid}, 32'd0);
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int cnt0, cnt1, k, n;
      req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
      res_ready = 1'b1;

      // Ready stays low while reset is asserted even with a valid request.
      rst = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b0;
      step();
      step();
      check("rst_ready0", {31'd0, req0_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_res_data", {24'd0, res_data}, 32'd0);
      check("rst_res_id", {31'd0, res_id}, 32'd0);
      req0_valid = 1'b0;
      rst = 1'b0;
      #1;

      do_op("single", 1'b0, 8'sd5, 8'sd3, 8'sd9);
      do_op("neg", 1'b1, -8'sd4, 8'sd2, -8'sd16);
      do_op("pos", 1'b0, 8'sd7, 8'sd1, 8'sd19);
      do_op("wrap", 1'b1, 8'sd100, -8'sd50, -8'sd112);

      // Fairness from reset: both requesters valid continuously.
      do_reset();
      req0_a = 8'sd1; req0_b = 8'sd0;
      req1_a = 8'sd2; req1_b = 8'sd1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      res_ready = 1'b1;
      #1;
      cnt0 = 0;
      cnt1 = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         k = cyc / 5;
         cnt0 += int'(req0_ready);
         cnt1 += int'(req1_ready);
         if (cyc % 5 == 0) begin
            check("fair_ready0", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("fair_ready1", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
         end
         if (cyc % 5 == 4) begin
            check("fair_valid", {31'd0, res_valid}, 32'd1);
            check("fair_id", {31'd0, res_id}, k % 2);
            check("fair_data", {24'd0, res_data}, (k % 2 == 1) ? 32'd4 : 32'd3);
         end
         step();
      end
      check("fair_cnt0", cnt0, 32'd2);
      check("fair_cnt1", cnt1, 32'd2);
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Backpressure: result held in DONE while req1 waits.
      do_reset();
      res_ready = 1'b0;
      req0_a = 8'sd2; req0_b = 8'sd1; req0_valid = 1'b1;
      #1;
      check("bp_ready0", {31'd0, req0_ready}, 32'd1);
      step();
      req0_valid = 1'b0;
      req1_a = 8'sd0; req1_b = 8'sd0; req1_valid = 1'b1;
      n = 1;
      while (!res_valid && n < 10) begin
         step();
         n++;
      end
      check("bp_latency", n, 32'd4);
      for (int i = 0; i < 3; i++) begin
         check("bp_hold_valid", {31'd0, res_valid}, 32'd1);
         check("bp_hold_data", {24'd0, res_data}, 32'd4);
         check("bp_hold_id", {31'd0, res_id}, 32'd0);
         check("bp_hold_ready1", {31'd0, req1_ready}, 32'd0);
         step();
      end
      res_ready = 1'b1;
      #1;
      check("bp_release_valid", {31'd0, res_valid}, 32'd1);
      check("bp_release_data", {24'd0, res_data}, 32'd4);
      step();
      check("bp_next_ready1", {31'd0, req1_ready}, 32'd1);
      step();
      req1_valid = 1'b0;
      n = 1;
      while (!res_valid && n < 10) begin
         step();
         n++;
      end
      check("bp_next_latency", n, 32'd4);
      check("bp_next_data", {24'd0, res_data}, 32'd0);
      check("bp_next_id", {31'd0, res_id}, 32'd1);
      step();

      // Reset during ADD discards the operation.
      req0_a = 8'sd3; req0_b = 8'sd3; req0_valid = 1'b1;
      #1;
      check("mid_ready0", {31'd0, req0_ready}, 32'd1);
      step();
      req0_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      check("mid_busy", {31'd0, busy}, 32'd0);
      check("mid_valid", {31'd0, res_valid}, 32'd0);
      check("mid_data", {24'd0, res_data}, 32'd0);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         n += int'(res_valid);
         step();
      end
      check("mid_no_pulse", n, 32'd0);
      do_op("after_rst", 1'b0, 8'sd1, 8'sd1, 8'sd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
